// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pattern_scan_ctrl
// Purpose  : Round-robin arbiter feeding an 8-bit word, MSB first, into a
//            4-bit serial pattern detector; reports match count per word.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_scan_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [7:0] data0,
   input  logic       req1,
   input  logic [7:0] data1,
   input  logic [3:0] pat,
   input  logic       overlap,
   output logic       gnt0,
   output logic       gnt1,
   output logic       busy,
   output logic       x,
   output logic       y,
   output logic       done,
   output logic       owner,
   output logic [3:0] match_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0] r_state;
   logic [1:0] w_next;

   logic [7:0] r_word;
   logic [3:0] r_pat;
   logic       r_ovl;
   logic [3:0] r_hist;
   logic [2:0] r_idx;
   logic [1:0] r_win;
   logic       r_last;
   logic       r_gnt0;
   logic       r_gnt1;
   logic       r_y;
   logic       r_done;
   logic       r_owner;
   logic [3:0] r_cnt;

   logic       w_any;
   logic       w_winner;
   logic       w_busy;
   logic       w_x;
   logic [3:0] w_window;
   logic       w_match;

   assign w_any    = req0 | req1;
   // On a tie the requester not served last wins; otherwise whoever asks.
   assign w_winner = (req0 & req1) ? ~r_last : req1;
   assign w_window = {r_hist[2:0], w_x};
   // r_win saturates at 3: three bits already in the window plus the current one.
   assign w_match  = (r_state == S_SHIFT) && (r_win == 2'd3) && (w_window == r_pat);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_next = S_SHIFT;
         S_SHIFT: if (r_idx == 3'd7) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_x    = 1'b0;
      case (r_state)
         S_SHIFT: begin
            w_busy = 1'b1;
            w_x    = r_word[3'd7 - r_idx];
         end
         S_DONE:  w_busy = 1'b1;
         default: begin
            w_busy = 1'b0;
            w_x    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word  <= 8'd0;
         r_pat   <= 4'd0;
         r_ovl   <= 1'b0;
         r_hist  <= 4'd0;
         r_idx   <= 3'd0;
         r_win   <= 2'd0;
         r_last  <= 1'b1;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_y     <= 1'b0;
         r_done  <= 1'b0;
         r_owner <= 1'b0;
         r_cnt   <= 4'd0;
      end else begin
         r_gnt0 <= 1'b0;
         r_gnt1 <= 1'b0;
         r_y    <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt0  <= ~w_winner;
                  r_gnt1  <= w_winner;
                  r_word  <= w_winner ? data1 : data0;
                  r_pat   <= pat;
                  r_ovl   <= overlap;
                  r_owner <= w_winner;
                  r_last  <= w_winner;
                  r_cnt   <= 4'd0;
                  r_hist  <= 4'd0;
                  r_idx   <= 3'd0;
                  r_win   <= 2'd0;
               end
            end
            S_SHIFT: begin
               r_idx <= r_idx + 3'd1;
               if (w_match && !r_ovl) begin
                  r_hist <= 4'd0;
                  r_win  <= 2'd0;
               end else begin
                  r_hist <= w_window;
                  r_win  <= (r_win == 2'd3) ? 2'd3 : r_win + 2'd1;
               end
               if (w_match) begin
                  r_y <= 1'b1;
                  if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
               end
            end
            // done is registered from DONE, so it pulses in the cycle after DONE.
            S_DONE: r_done <= 1'b1;
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign gnt0      = r_gnt0;
   assign gnt1      = r_gnt1;
   assign busy      = w_busy;
   assign x         = w_x;
   assign y         = r_y;
   assign done      = r_done;
   assign owner     = r_owner;
   assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pattern_scan_ctrl
// Purpose  : Directed self-checking bench for pattern_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [7:0] data0 = 8'd0;
   logic [7:0] data1 = 8'd0;
   logic [3:0] pat = 4'd0;
   logic       overlap = 1'b0;
   logic       gnt0, gnt1, busy, x, y, done, owner;
   logic [3:0] match_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int g1, g2;

   pattern_scan_ctrl u_dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .data0     (data0),
      .req1      (req1),
      .data1     (data1),
      .pat       (pat),
      .overlap   (overlap),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .busy      (busy),
      .x         (x),
      .y         (y),
      .done      (done),
      .owner     (owner),
      .match_cnt (match_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, " gnt0"}, gnt0, 0);
      check({tag, " gnt1"}, gnt1, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " x"}, x, 0);
      check({tag, " y"}, y, 0);
      check({tag, " done"}, done, 0);
      check({tag, " owner"}, owner, 0);
      check({tag, " match_cnt"}, match_cnt, 0);
   endtask

   // Waits for a grant, then follows the scan to one cycle past DONE.
   // exp_y bit k-1 set means y is high k cycles after the gnt cycle.
   task automatic scan(input string tag, input bit exp_owner, input logic [7:0] exp_y,
                       input logic [3:0] exp_cnt, input bit toggle, output int gcyc);
      bit         got;
      logic [7:0] ymask;
      int         done_off, done_n;
      bit         extra_gnt, busy_bad, y_late;
      logic [3:0] cnt_fin;
      logic       own_fin;
      got = 0;
      gcyc = 0;
      for (int n = 0; n < 30 && !got; n++) begin
         tick();
         if (gnt0 | gnt1) got = 1;
      end
      check({tag, " granted"}, got, 1);
      if (!got) return;
      gcyc = cyc;
      check({tag, " gnt"}, {gnt1, gnt0}, exp_owner ? 2'b10 : 2'b01);
      check({tag, " busy@gnt"}, busy, 1);
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      ymask = 8'd0; done_off = -1; done_n = 0;
      extra_gnt = 0; busy_bad = 0; y_late = 0;
      cnt_fin = 4'd0; own_fin = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         if (toggle && k == 3) begin
            pat = ~pat; overlap = ~overlap; data0 = ~data0; data1 = ~data1;
         end
         tick();
         if (k <= 8 && y) ymask[k-1] = 1'b1;
         if (k == 9 && y) y_late = 1;
         if (done) begin
            done_n++;
            if (done_off < 0) done_off = k;
         end
         if (gnt0 | gnt1) extra_gnt = 1;
         if ((k <= 8) != busy) busy_bad = 1;
         if (k == 9) begin
            cnt_fin = match_cnt;
            own_fin = owner;
         end
      end
      check({tag, " y pattern"}, ymask, exp_y);
      check({tag, " y after done"}, y_late, 0);
      check({tag, " done offset"}, done_off, 9);
      check({tag, " done pulses"}, done_n, 1);
      check({tag, " grant while busy"}, extra_gnt, 0);
      check({tag, " busy window"}, busy_bad, 0);
      check({tag, " match_cnt"}, cnt_fin, exp_cnt);
      check({tag, " owner"}, own_fin, exp_owner);
   endtask

   initial begin
      bit got;
      rst = 1'b1;
      repeat (3) tick();
      check_cleared("reset");
      rst = 1'b0;

      pat = 4'b1010; overlap = 1'b1; data0 = 8'hAA; req0 = 1'b1;
      scan("aa_ov1", 0, 8'hA8, 4'd3, 0, g1);
      overlap = 1'b0; req0 = 1'b1;
      scan("aa_ov0", 0, 8'h88, 4'd2, 0, g1);
      pat = 4'b1111; overlap = 1'b1; data0 = 8'hFF; req0 = 1'b1;
      scan("ff_1111", 0, 8'hF8, 4'd5, 0, g1);
      pat = 4'b1010; data0 = 8'h00; req0 = 1'b1;
      scan("zero", 0, 8'h00, 4'd0, 0, g1);
      pat = 4'b1010; overlap = 1'b1; data1 = 8'hAA; req1 = 1'b1;
      scan("pat_toggle", 1, 8'hA8, 4'd3, 1, g1);

      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      pat = 4'b1010; overlap = 1'b1; data0 = 8'hAA; data1 = 8'hFF;
      req0 = 1'b1; req1 = 1'b1;
      scan("tie_a", 0, 8'hA8, 4'd3, 0, g1);
      scan("tie_b", 1, 8'h00, 4'd0, 0, g2);
      check("tie spacing", g2 - g1, 10);
      req0 = 1'b1; req1 = 1'b1;
      scan("tie_c", 0, 8'hA8, 4'd3, 0, g1);
      scan("tie_d", 1, 8'h00, 4'd0, 0, g2);

      data1 = 8'hAA; req1 = 1'b1;
      got = 0;
      for (int n = 0; n < 30 && !got; n++) begin
         tick();
         if (gnt1) got = 1;
      end
      check("rst_mid granted", got, 1);
      req1 = 1'b0;
      repeat (4) tick();
      check("rst_mid busy", busy, 1);
      rst = 1'b1; req1 = 1'b1;
      tick();
      check_cleared("rst_mid");
      rst = 1'b0;
      scan("post_rst", 1, 8'hA8, 4'd3, 0, g1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 scan request; held until gnt0
- data0  in  8  requester 0 word; held valid while req0=1
- req1  in  1  requester 1 scan request; held until gnt1
- data1  in  8  requester 1 word; held valid while req1=1
- pat  in  4  detect pattern, first bit in pat[3]
- overlap  in  1  1=overlapping detection, 0=non-overlapping
- gnt0  out  1  one-cycle grant pulse to requester 0
- gnt1  out  1  one-cycle grant pulse to requester 1
- busy  out  1  scan in progress (state SHIFT or DONE)
- x  out  1  serial bit currently presented to the detector
- y  out  1  one-cycle detect pulse
- done  out  1  one-cycle result-valid pulse
- owner  out  1  requester index of the current or last scan
- match_cnt  out  4  matches found in the current or last word

Function
REQ-002 The block SHALL be an FSM with three states: IDLE, SHIFT and DONE.
REQ-003 In IDLE, when any request is high, the block SHALL grant on the next edge:
- gnt of the winner =1 for exactly that one cycle
- latch the winner's data, pat and overlap
- load owner; clear match_cnt and history
- bit index =0; state -> SHIFT
REQ-004 Arbitration SHALL be round-robin: when both requests are high, the grant SHALL go to the requester not served last; a single request SHALL always win.
REQ-005 The last-served pointer SHALL reset to 1, so that requester 0 wins the first tie.
REQ-006 The block SHALL NOT grant in SHIFT or DONE; requests in those states SHALL wait.
REQ-007 In SHIFT, x SHALL equal the latched word bit [7-index], MSB first.
REQ-008 On each SHIFT edge, x SHALL shift into a 4-bit history and the index SHALL increment.
REQ-009 SHIFT SHALL last exactly 8 cycles; after the edge that consumes bit 0, the state SHALL go to DONE.
REQ-010 A match SHALL occur on the edge where {history[2:0], x} equals the latched pat and at least 4 bits of the current window have been consumed.
REQ-011 On a match the block SHALL increment match_cnt.
REQ-012 On a match, y SHALL be 1 in the following cycle only; a match on bit 0 SHALL give y=1 during DONE.
REQ-013 On a match with overlap=1, history SHALL keep the shifted value.
REQ-014 On a match with overlap=0, the window SHALL restart: history cleared and the 4-bit count restarted.
REQ-015 match_cnt SHALL range 0..5 and SHALL never wrap.
REQ-016 In DONE, done SHALL be 1 for one cycle; match_cnt and owner SHALL be final and SHALL hold until the next grant.
REQ-017 DONE SHALL always return to IDLE; the earliest next gnt SHALL be one cycle after done.
REQ-018 Latency SHALL be fixed: done SHALL rise 9 cycles after the gnt cycle.
REQ-019 Changes to pat, overlap or data during a scan SHALL have no effect.
REQ-020 busy SHALL be 1 in SHIFT and DONE; x SHALL be 0 outside SHIFT.

Reset
REQ-021 When rst=1 on an edge, the block SHALL enter IDLE and clear all outputs to 0 (gnt0, gnt1, busy, x, y, done, owner, match_cnt).
REQ-022 Reset SHALL also clear history and index and set the last-served pointer to 1.
REQ-023 A reset mid-scan SHALL abandon the scan without asserting done; a request held through reset SHALL be granted afresh after reset releases.

Verification
REQ-024 The bench SHALL cover these scenarios:
- pat=1010, overlap=1, req0 with data0=8'hAA -> gnt0 one cycle; y after bits 4,6,8; done with match_cnt=3, owner=0
- Same with overlap=0 -> y after bits 4,8; match_cnt=2
- pat=1111, overlap=1, data=8'hFF -> match_cnt=5; pat=1010, data=8'h00 -> match_cnt=0, y never high
- req0 and req1 high together from reset -> gnt0 first, done owner=0, then gnt1, done owner=1; a later tie goes to requester 0
- rst=1 during the 5th SHIFT cycle -> next cycle all outputs 0; no done; held req1 then granted normally
- pat toggled mid-scan -> result matches the pat latched at grant; gnt-to-done spacing is 9 cycles in every scenario
